// File: rtl/sevenseg_scan_decoder_if.sv
// Multiplexed seven-segment display bus plus the recovered per-digit results.
// The display side drives an_in/seg_in; the decoder returns captures and pulses.
interface sevenseg_scan_decoder_if #(
   parameter int NDIG = 4
);
   logic [NDIG-1:0]   an_in;
   logic [6:0]        seg_in;
   logic [4*NDIG-1:0] bcd_out;
   logic [NDIG-1:0]   digit_valid;
   logic [NDIG-1:0]   digit_err;
   logic              cap_pulse;
   logic              frame_done;

   modport master (
      output an_in, seg_in,
      input  bcd_out, digit_valid, digit_err, cap_pulse, frame_done
   );

   modport slave (
      input  an_in, seg_in,
      output bcd_out, digit_valid, digit_err, cap_pulse, frame_done
   );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Recovers BCD digits from an active-low multiplexed seven-segment bus.
// Each digit is captured once after its {anode,segment} value holds steady.
module sevenseg_scan_decoder #(
   parameter int NDIG          = 4,
   parameter int STABLE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   sevenseg_scan_decoder_if.slave bus
);
   localparam int W  = NDIG + 7;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   // Returns {err, code}; blank maps to F without error, unknown patterns to E with error.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b0000001: r = 5'h00;
         7'b1001111: r = 5'h01;
         7'b0010010: r = 5'h02;
         7'b0000110: r = 5'h03;
         7'b1001100: r = 5'h04;
         7'b0100100: r = 5'h05;
         7'b0100000: r = 5'h06;
         7'b0001111: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0000100: r = 5'h09;
         7'b1111111: r = 5'h0F;
         default:    r = 5'h1E;
      endcase
      return r;
   endfunction

   state_t            state_r;
   logic [W-1:0]      sync1_r;
   logic [W-1:0]      sync2_r;
   logic [W-1:0]      prev_r;
   logic [CW-1:0]     cnt_r;
   logic [NDIG-1:0]   seen_r;
   logic [4*NDIG-1:0] bcd_r;
   logic [NDIG-1:0]   valid_r;
   logic [NDIG-1:0]   err_r;
   logic              cap_pulse_r;
   logic              frame_done_r;

   logic [NDIG-1:0]   an_s;
   logic [NDIG-1:0]   hit_s;
   logic [NDIG-1:0]   full_s;
   logic [6:0]        seg_s;
   logic [4:0]        dec_s;
   logic              chg_s;
   logic              onehot_s;

   // The change flag compares s with its previous value, so a new s is seen one edge after it lands.
   assign an_s     = sync2_r[W-1:7];
   assign seg_s    = sync2_r[6:0];
   assign hit_s    = ~an_s;
   assign full_s   = seen_r | hit_s;
   assign chg_s    = (sync2_r != prev_r);
   assign onehot_s = $onehot(hit_s);
   assign dec_s    = decode_seg(seg_s);

   // Input synchronizer, change history and stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= {W{1'b1}};
         sync2_r <= {W{1'b1}};
         prev_r  <= {W{1'b1}};
         cnt_r   <= '0;
      end else begin
         sync1_r <= {bus.an_in, bus.seg_in};
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         if (chg_s) begin
            cnt_r <= CNT_ONE;
         end else if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Scan FSM with capture registers and frame tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         seen_r       <= '0;
         bcd_r        <= '0;
         valid_r      <= '0;
         err_r        <= '0;
         cap_pulse_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         cap_pulse_r  <= 1'b0;
         frame_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               state_r <= onehot_s ? SETTLE : IDLE;
            end
            SETTLE: begin
               if (chg_s) begin
                  state_r <= onehot_s ? SETTLE : IDLE;
               end else if (cnt_r == CNT_CAP) begin
                  state_r     <= CAPTURED;
                  cap_pulse_r <= 1'b1;
                  for (int i = 0; i < NDIG; i++) begin
                     if (hit_s[i]) begin
                        bcd_r[4*i +: 4] <= dec_s[3:0];
                        err_r[i]        <= dec_s[4];
                     end
                  end
                  valid_r <= valid_r | hit_s;
                  // The digit that completes a frame starts the next frame from empty.
                  if (&full_s) begin
                     seen_r       <= '0;
                     frame_done_r <= 1'b1;
                  end else begin
                     seen_r <= full_s;
                  end
               end else begin
                  state_r <= SETTLE;
               end
            end
            CAPTURED: begin
               if (chg_s) begin
                  state_r <= onehot_s ? SETTLE : IDLE;
               end else begin
                  state_r <= CAPTURED;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.bcd_out     = bcd_r;
   assign bus.digit_valid = valid_r;
   assign bus.digit_err   = err_r;
   assign bus.cap_pulse   = cap_pulse_r;
   assign bus.frame_done  = frame_done_r;
endmodule
